// File: rtl/accum_pkg.sv
// Shared defaults for the accumulator window sampler and its FIFO.
package accum_pkg;

    localparam int unsigned ACC_N     = 4;
    localparam int unsigned ACC_WIN   = 4;
    localparam int unsigned ACC_DEPTH = 4;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/accum_window_sampler_sync_fifo.sv
// Synchronous FIFO; head is presented combinationally and reads 0 when empty.
module sync_fifo
    import accum_pkg::*;
#(
    parameter int unsigned N     = ACC_N,
    parameter int unsigned DEPTH = ACC_DEPTH
) (
    input  logic                            Clk,
    input  logic                            Resetn,
    input  logic                            Push,
    input  logic                            Pop,
    input  logic [N-1:0]                    Din,
    output logic [N-1:0]                    Dout,
    output logic                            Full,
    output logic                            Empty,
    output logic [count_width(DEPTH)-1:0]   Count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign Full  = (Count == CW'(DEPTH));
    assign Empty = (Count == '0);

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign do_pop  = Pop && !Empty;
    assign do_push = Push && (!Full || do_pop);

    assign Dout = Empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= Din;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

endmodule

// File: rtl/accum_window_sampler.sv
// Samples an upstream accumulator every WIN enables and queues the per-window sum.
module accum_window_sampler
    import accum_pkg::*;
#(
    parameter int unsigned N     = ACC_N,
    parameter int unsigned WIN   = ACC_WIN,
    parameter int unsigned DEPTH = ACC_DEPTH
) (
    input  logic                            Clk,
    input  logic                            Resetn,
    input  logic                            En,
    input  logic [N-1:0]                    Q,
    input  logic                            Clr_Ovf,
    input  logic                            Out_Ready,
    output logic [N-1:0]                    Out_Data,
    output logic                            Out_Valid,
    output logic [count_width(DEPTH)-1:0]   Count,
    output logic                            Overflow
);

    localparam int unsigned WW = $clog2(WIN);
    localparam logic [WW-1:0] LAST = WW'(WIN - 1);

    logic [WW-1:0] win_cnt;
    logic          capture_pending;
    logic [N-1:0]  prev;
    logic [N-1:0]  sum;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;

    assign sum       = Q - prev;
    assign Out_Valid = !empty;
    assign pop       = Out_Valid && Out_Ready;
    assign drop      = capture_pending && full && !pop;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            win_cnt         <= '0;
            capture_pending <= 1'b0;
        end else begin
            // Q lags En by one edge, so the sample is taken the cycle after the last enable.
            capture_pending <= En && (win_cnt == LAST);
            if (En) begin
                win_cnt <= (win_cnt == LAST) ? '0 : win_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            prev     <= '0;
            Overflow <= 1'b0;
        end else begin
            if (capture_pending) begin
                prev <= Q;
            end
            if (drop) begin
                Overflow <= 1'b1;
            end else if (Clr_Ovf) begin
                Overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk    (Clk),
        .Resetn (Resetn),
        .Push   (capture_pending),
        .Pop    (pop),
        .Din    (sum),
        .Dout   (Out_Data),
        .Full   (full),
        .Empty  (empty),
        .Count  (Count)
    );

endmodule

// File: tb/tb_accum_window_sampler.sv
// Directed bench: a behavioural accumulator feeds Q; expected sums are hand-computed.
module tb_accum_window_sampler;

    logic       Clk;
    logic       Resetn;
    logic       En;
    logic [3:0] Data;
    logic [3:0] Q;
    logic       Clr_Ovf;
    logic       Out_Ready;
    logic [3:0] Out_Data;
    logic       Out_Valid;
    logic [2:0] Count;
    logic       Overflow;

    int total = 0;
    int bad   = 0;

    accum_window_sampler #(
        .N     (4),
        .WIN   (4),
        .DEPTH (4)
    ) dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .En        (En),
        .Q         (Q),
        .Clr_Ovf   (Clr_Ovf),
        .Out_Ready (Out_Ready),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Count     (Count),
        .Overflow  (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Upstream accumulator: Q updates on the edge where En is seen.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) Q <= '0;
        else if (En) Q <= Q + Data;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_en(input logic [3:0] d);
        En   = 1'b1;
        Data = d;
        tick();
        En   = 1'b0;
        Data = '0;
    endtask

    task automatic do_window(input logic [3:0] d);
        do_en(d);
        do_en(4'd0);
        do_en(4'd0);
        do_en(4'd0);
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        En = 1'b0; Data = '0; Clr_Ovf = 1'b0; Out_Ready = 1'b0;
        Resetn = 1'b0;
        #3;
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", Count); end
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", Out_Valid); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", Overflow); end
        total++; if (Out_Data !== 4'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", Out_Data); end
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_first_windows();
        Out_Ready = 1'b1;
        do_en(4'd1); do_en(4'd2); do_en(4'd3); do_en(4'd4);
        total++; if (Q !== 4'd10) begin bad++; $display("FAIL w1_q got=%0d want=10", Q); end
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL w1_valid_early got=%b want=0", Out_Valid); end
        tick();
        total++; if (Out_Valid !== 1'b1) begin bad++; $display("FAIL w1_valid got=%b want=1", Out_Valid); end
        total++; if (Out_Data !== 4'd10) begin bad++; $display("FAIL w1_data got=%0d want=10", Out_Data); end
        tick();
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL w1_popped got=%b want=0", Out_Valid); end
        do_en(4'd5); do_en(4'd5); do_en(4'd5); do_en(4'd5);
        total++; if (Q !== 4'd14) begin bad++; $display("FAIL w2_q got=%0d want=14", Q); end
        tick();
        total++; if (Out_Data !== 4'd4) begin bad++; $display("FAIL w2_data got=%0d want=4", Out_Data); end
        total++; if (dut.prev !== 4'd14) begin bad++; $display("FAIL w2_prev got=%0d want=14", dut.prev); end
        tick();
    endtask

    task automatic test_overflow_drain();
        apply_reset();
        Out_Ready = 1'b0;
        for (int unsigned k = 1; k <= 5; k++) do_window(4'(k));
        tick();
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", Count); end
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", Overflow); end
        total++; if (dut.prev !== 4'd15) begin bad++; $display("FAIL ovf_prev got=%0d want=15", dut.prev); end
        Out_Ready = 1'b1;
        for (int unsigned k = 1; k <= 4; k++) begin
            total++; if (Out_Data !== 4'(k)) begin bad++; $display("FAIL drain_%0d got=%0d want=%0d", k, Out_Data, k); end
            tick();
        end
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", Out_Valid); end
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", Count); end
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", Overflow); end
        Clr_Ovf = 1'b1; tick(); Clr_Ovf = 1'b0;
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b want=0", Overflow); end
        // Q goes 15 -> 5 (wrapped); sum from prev 15 is 6.
        do_window(4'd6);
        tick();
        total++; if (Out_Data !== 4'd6) begin bad++; $display("FAIL after_drop_sum got=%0d want=6", Out_Data); end
        tick();
    endtask

    task automatic test_full_with_pop();
        apply_reset();
        Out_Ready = 1'b0;
        for (int unsigned k = 1; k <= 5; k++) do_window(4'(k));
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d want=4", Count); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b want=0", Overflow); end
        total++; if (Out_Data !== 4'd2) begin bad++; $display("FAIL fullpop_head got=%0d want=2", Out_Data); end
        tick();
        total++; if (Out_Data !== 4'd2) begin bad++; $display("FAIL hold_head got=%0d want=2", Out_Data); end
        Out_Ready = 1'b1;
        for (int unsigned k = 2; k <= 5; k++) begin
            total++; if (Out_Data !== 4'(k)) begin bad++; $display("FAIL fullpop_drain_%0d got=%0d want=%0d", k, Out_Data, k); end
            tick();
        end
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b want=0", Out_Valid); end
    endtask

    task automatic test_clr_vs_drop();
        apply_reset();
        Out_Ready = 1'b0;
        for (int unsigned k = 1; k <= 5; k++) do_window(4'(k));
        Clr_Ovf = 1'b1; tick(); Clr_Ovf = 1'b0;
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL clr_drop_same got=%b want=1", Overflow); end
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL clr_drop_count got=%0d want=4", Count); end
        Clr_Ovf = 1'b1; tick(); Clr_Ovf = 1'b0;
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL clr_after got=%b want=0", Overflow); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        Out_Ready = 1'b0;
        do_window(4'd1);
        do_window(4'd2);
        tick();
        do_en(4'd3); do_en(4'd4);
        total++; if (Count !== 3'd2) begin bad++; $display("FAIL pre_reset_count got=%0d want=2", Count); end
        Resetn = 1'b0;
        #2;
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d want=0", Count); end
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", Out_Valid); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf got=%b want=0", Overflow); end
        #1;
        Resetn = 1'b1;
        #1;
        do_en(4'd3);
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL no_push_after_reset got=%0d want=0", Count); end
        do_en(4'd1); do_en(4'd2); do_en(4'd7);
        tick();
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL fresh_count got=%0d want=1", Count); end
        total++; if (Out_Data !== 4'd13) begin bad++; $display("FAIL fresh_sum got=%0d want=13", Out_Data); end
    endtask

    initial begin
        test_reset();
        test_first_windows();
        test_overflow_drain();
        test_full_with_pop();
        test_clr_vs_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_window_sampler.md
ACCUM_WINDOW_SAMPLER -- requirements
Module: accum_window_sampler

Interface
REQ-001 The block SHALL have parameter N, default 4: data width, matching the upstream accumulator width.
REQ-002 The block SHALL have parameter WIN, default 4: accumulator enables per window, WIN >= 2.
REQ-003 The block SHALL have parameter DEPTH, default 4: output FIFO depth, a power of 2, >= 2.
REQ-004 The block SHALL have port Clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port Resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port En, input, 1 bit: the same enable that drives the accumulator.
REQ-007 The block SHALL have port Q, input, N bits: the accumulator running-sum output.
REQ-008 The block SHALL have port Clr_Ovf, input, 1 bit: synchronous clear of Overflow.
REQ-009 The block SHALL have port Out_Ready, input, 1 bit: consumer ready.
REQ-010 The block SHALL have port Out_Data, output, N bits: window sum at the FIFO head.
REQ-011 The block SHALL have port Out_Valid, output, 1 bit: FIFO non-empty.
REQ-012 The block SHALL have port Count, output, $clog2(DEPTH+1) bits: FIFO occupancy.
REQ-013 The block SHALL have port Overflow, output, 1 bit: sticky flag set when a window sum was dropped.

Function
REQ-014 The window counter SHALL count cycles with En=1 over 0..WIN-1, wrapping to 0 after WIN-1.
REQ-015 En=1 while the counter equals WIN-1 SHALL set a one-cycle capture_pending flag in the next cycle, because Q updates one edge after En.
REQ-016 While capture_pending=1, the block SHALL compute the window sum as (Q - Prev) mod 2^N, push it, and load Prev <= Q on the same edge.
REQ-017 En during a capture_pending cycle SHALL count toward the next window; windows SHALL be back-to-back with no lost enables.
REQ-018 A pop SHALL occur on a rising edge where Out_Valid=1 and Out_Ready=1.
REQ-019 Out_Data SHALL always equal the head entry and SHALL be stable while Out_Valid=1 and Out_Ready=0.
REQ-020 Out_Valid SHALL equal (Count != 0).
REQ-021 There SHALL be no bypass: a push into an empty FIFO SHALL assert Out_Valid one cycle after the push edge.
REQ-022 A push with Count < DEPTH SHALL be stored.
REQ-023 A push with Count = DEPTH and a simultaneous pop SHALL be stored, leaving Count unchanged.
REQ-024 A push with Count = DEPTH and no pop SHALL be dropped and SHALL set Overflow on that edge; FIFO contents SHALL be unchanged.
REQ-025 Prev SHALL be updated even when the sum is dropped, so that later windows stay correct.
REQ-026 Clr_Ovf=1 SHALL clear Overflow on the next edge; if a drop occurs on the same edge, the set SHALL win.
REQ-027 A pop with Count = 0 SHALL be impossible, since Out_Valid=0; Out_Ready SHALL be ignored in that case.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; Count SHALL saturate neither above DEPTH nor below 0.

Reset
REQ-029 Resetn low SHALL asynchronously clear the window counter, capture_pending, Prev (0, matching the accumulator reset value), the FIFO pointers, Count, Overflow, and Out_Valid.
REQ-030 Out_Data SHALL read 0 during reset.
REQ-031 A reset mid-window or mid-drain SHALL discard the partial window and all queued entries; no push SHALL occur on the first edge after deassertion.

Structure
REQ-032 Package accum_pkg SHALL hold the default constants ACC_N=4, ACC_WIN=4, and ACC_DEPTH=4, plus a function that computes the Count width.
REQ-033 The FIFO SHALL be a sub-module sync_fifo (N, DEPTH; push/pop/full/empty/count) instantiated once.
REQ-034 The window counter, capture logic, Prev, and the Overflow flag SHALL reside in the top module.

Verification
REQ-035 With N=4, WIN=4, DEPTH=4, Out_Ready=1, Data 1,2,3,4 driven into a real Accum, Q SHALL run 1,3,6,10, Out_Data SHALL be 10, and Out_Valid SHALL pulse 2 cycles after the 4th En.
REQ-036 A second window of Data 5,5,5,5 SHALL take Q to 14 (wrapped), Out_Data SHALL be 4 (20 mod 16), and Prev SHALL become 14.
REQ-037 With Out_Ready=0 and 5 windows completed, Count SHALL reach 4 and Overflow SHALL be 1; draining SHALL return windows 1-4 in order and SHALL never return the 5th.
REQ-038 With Count=4, a 5th capture coincident with Out_Ready=1 SHALL be stored, Count SHALL stay 4, and Overflow SHALL stay 0.
REQ-039 Clr_Ovf and a drop on the same edge SHALL leave Overflow=1; Clr_Ovf alone SHALL give Overflow=0 on the next cycle.
REQ-040 Resetn pulsed low after 2 enables, with 2 entries queued, SHALL give Count=0, Out_Valid=0, and Overflow=0 immediately; the next 4 enables SHALL produce a sum equal to the fresh Q.
